// File: rtl/nios_system_entity_cmd_out_pkg.sv
// Purpose : shared constants for the entity command output port (register map + STATUS bits).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// The software header mirrors these values; keep them in lock-step.
package nios_system_entity_cmd_out_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // STATUS/CTRL bit positions
    localparam int VALID = 0;
    localparam int OVF   = 1;
    localparam int IEN   = 2;
    localparam int DONE  = 3;

    // Assemble the STATUS read word; unlisted bits read 0.
    function automatic logic [31:0] status_word(input logic valid, input logic ovf,
                                                input logic ien, input logic done);
        logic [31:0] w;
        w        = '0;
        w[VALID] = valid;
        w[OVF]   = ovf;
        w[IEN]   = ien;
        w[DONE]  = done;
        return w;
    endfunction

endpackage

// File: rtl/nios_system_entity_cmd_out_if.sv
// Purpose : bundles the Avalon-MM slave bus and the command valid/ack stream of the entity port.
// Latency : n/a (wiring only).
// Backpressure: out_ack from the consumer; CPU paces itself via STATUS/COUNT/irq.
//
// Signals:
//   address/chipselect/write_n/writedata/readdata : Avalon-MM slave, read latency 1
//   out_port/out_valid/out_ack                     : command word handshake to the consumer
//   irq                                            : level interrupt to the CPU
interface nios_system_entity_cmd_out_if #(
    parameter int DATA_WIDTH = 2
);
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [DATA_WIDTH-1:0] out_port;
    logic                  out_valid;
    logic                  out_ack;
    logic                  irq;

    // The port block itself
    modport slave (
        input  address, chipselect, write_n, writedata, out_ack,
        output readdata, out_port, out_valid, irq
    );

    // CPU interconnect plus consumer, as seen from outside the block
    modport master (
        output address, chipselect, write_n, writedata, out_ack,
        input  readdata, out_port, out_valid, irq
    );
endinterface

// File: rtl/nios_system_entity_cmd_out.sv
// Purpose : Avalon-MM command output port with valid/ack handshake, sticky overflow, completion counter, done irq.
// Latency : DATA write -> out_valid 1 cycle; read data 1 cycle; done -> irq 1 cycle.
// Backpressure: a DATA write while a command is pending and not acked that cycle is dropped and flags overflow.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : nios_system_entity_cmd_out_if slave modport (Avalon slave + command stream + irq)
module nios_system_entity_cmd_out
    import nios_system_entity_cmd_out_pkg::*;
#(
    parameter int          DATA_WIDTH  = 2,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    nios_system_entity_cmd_out_if.slave          bus
);

    localparam logic [DATA_WIDTH-1:0] PORT_RST = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] out_port;
    logic                  out_valid;
    logic                  overflow;
    logic                  done;
    logic                  ien;
    logic [7:0]            count;
    logic                  irq;
    logic [31:0]           readdata;

    logic        wr;
    logic        wr_data;
    logic        wr_status;
    logic        wr_count;
    logic        ack_fire;
    logic        free;
    logic        accept;
    logic [31:0] rd_mux;

    // Only part of writedata is architecturally meaningful.
    logic unused_wd;
    assign unused_wd = &{1'b0, bus.writedata};

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_data   = wr & (bus.address == ADDR_DATA);
    assign wr_status = wr & (bus.address == ADDR_STATUS);
    assign wr_count  = wr & (bus.address == ADDR_COUNT);

    assign ack_fire  = out_valid & bus.out_ack;
    // The slot is free if empty or if the current word is being consumed this very edge.
    assign free      = ~out_valid | bus.out_ack;
    assign accept    = wr_data & free;

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA:   rd_mux[DATA_WIDTH-1:0] = out_port;
            ADDR_STATUS: rd_mux = status_word(out_valid, overflow, ien, done);
            ADDR_COUNT:  rd_mux[7:0] = count;
            default:     rd_mux = '0;
        endcase
    end

    // Command register and handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port  <= PORT_RST;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_port  <= bus.writedata[DATA_WIDTH-1:0];
            out_valid <= 1'b1;
        end else if (ack_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Status/control, counter, interrupt and read register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            done     <= 1'b0;
            ien      <= 1'b0;
            count    <= 8'd0;
            irq      <= 1'b0;
            readdata <= 32'd0;
        end else begin
            readdata <= rd_mux;
            // Uses pre-edge done/ien, so irq trails done by one cycle.
            irq      <= ien & done;

            if (wr_data && !free)
                overflow <= 1'b1;
            else if (wr_status && bus.writedata[OVF])
                overflow <= 1'b0;

            // Completion set beats a software clear in the same cycle.
            if (ack_fire)
                done <= 1'b1;
            else if (wr_status && bus.writedata[DONE])
                done <= 1'b0;

            if (wr_status)
                ien <= bus.writedata[IEN];

            // Software clear beats a completion increment in the same cycle.
            if (wr_count)
                count <= 8'd0;
            else if (ack_fire)
                count <= count + 8'd1;
        end
    end

    assign bus.out_port  = out_port;
    assign bus.out_valid = out_valid;
    assign bus.irq       = irq;
    assign bus.readdata  = readdata;

endmodule

// File: tb/tb_nios_system_entity_cmd_out.sv
// Purpose : self-checking bench for nios_system_entity_cmd_out (directed scenarios + random traffic vs a queue model).
// Latency : n/a.
// Backpressure: n/a.
module tb_nios_system_entity_cmd_out;

    localparam int          DW   = 2;
    localparam logic [31:0] RSTV = 32'd1;

    logic clk;
    logic reset_n;

    nios_system_entity_cmd_out_if #(.DATA_WIDTH(DW)) bus ();

    nios_system_entity_cmd_out #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (RSTV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A pending command is an entry in a one-deep queue; the port shows the last word taken.
    logic [DW-1:0] pending[$];
    logic [DW-1:0] m_port;
    bit            m_ovf, m_done, m_ien, m_irq;
    int            m_count;
    logic [31:0]   m_rd;
    bit            cmp_en = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending.delete();
            m_port  = RSTV[DW-1:0];
            m_ovf   = 0; m_done = 0; m_ien = 0; m_irq = 0;
            m_count = 0;
            m_rd    = 0;
        end else begin
            bit wr;
            bit old_ien, old_done;
            wr       = bus.chipselect && !bus.write_n;
            old_ien  = m_ien;
            old_done = m_done;
            case (bus.address)
                2'd0:    m_rd = 32'(m_port);
                2'd1:    m_rd = 32'((pending.size() != 0) + 2*m_ovf + 4*m_ien + 8*m_done);
                2'd2:    m_rd = 32'(m_count);
                default: m_rd = 0;
            endcase
            if (wr && bus.address == 2'd1) begin
                if (bus.writedata[1]) m_ovf = 0;
                if (bus.writedata[3]) m_done = 0;
                m_ien = bus.writedata[2];
            end
            if (bus.out_ack && pending.size() != 0) begin
                void'(pending.pop_front());
                m_done  = 1;
                m_count = (m_count + 1) % 256;
            end
            if (wr && bus.address == 2'd2) m_count = 0;
            if (wr && bus.address == 2'd0) begin
                if (pending.size() == 0) begin
                    pending.push_back(bus.writedata[DW-1:0]);
                    m_port = bus.writedata[DW-1:0];
                end else begin
                    m_ovf = 1;
                end
            end
            m_irq = old_ien && old_done;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_port",  32'(bus.out_port), 32'(m_port));
            chk("out_valid", 32'(bus.out_valid), 32'(pending.size() != 0));
            chk("irq",       32'(bus.irq), 32'(m_irq));
            chk("readdata",  bus.readdata, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic ack);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        bus.out_ack    = ack;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input logic ack);
        cyc(a, 1'b1, 1'b0, wd, ack);
    endtask

    task automatic idle(input logic [1:0] a);
        cyc(a, 1'b0, 1'b1, 32'd0, 1'b0);
    endtask

    // Present a read address for one cycle; readdata is valid once the next cycle starts.
    task automatic rd_reg(input logic [1:0] a, input string name, input logic [31:0] exp);
        idle(a);
        idle(2'd3);
        #2 chk(name, bus.readdata, exp);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.address    = 2'd3;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        bus.out_ack    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_readdata",  bus.readdata, 32'd0);
        chk("rst_out_port",  32'(bus.out_port), 32'(RSTV[DW-1:0]));
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_irq",       32'(bus.irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cmp_en  = 1;
        rd_reg(2'd1, "rst_status", 32'h0);

        // Single command held without ack
        wr_reg(2'd0, 32'hFFFF_FFF3, 1'b0);
        idle(2'd3);
        #2 chk("cmd_valid", 32'(bus.out_valid), 32'd1);
        chk("cmd_port", 32'(bus.out_port), 32'h3);
        repeat (10) idle(2'd3);
        #2 chk("cmd_stable", 32'(bus.out_port), 32'h3);
        rd_reg(2'd1, "status_pending", 32'h1);
        rd_reg(2'd0, "data_read", 32'h3);

        // Overflow on write while pending
        wr_reg(2'd0, 32'h1, 1'b0);
        idle(2'd3);
        #2 chk("ovf_port_kept", 32'(bus.out_port), 32'h3);
        rd_reg(2'd1, "status_ovf", 32'h3);
        wr_reg(2'd1, 32'h2, 1'b0);
        rd_reg(2'd1, "status_ovf_clr", 32'h1);

        // Completion, done, irq
        wr_reg(2'd1, 32'h4, 1'b0);
        cyc(2'd3, 1'b0, 1'b1, 32'd0, 1'b1);
        idle(2'd3);
        #2 chk("ack_valid", 32'(bus.out_valid), 32'd0);
        chk("irq_not_yet", 32'(bus.irq), 32'd0);
        idle(2'd3);
        #2 chk("irq_set", 32'(bus.irq), 32'd1);
        rd_reg(2'd1, "status_done", 32'hC);
        rd_reg(2'd2, "count_one", 32'd1);
        wr_reg(2'd1, 32'h8, 1'b0);
        idle(2'd3);
        idle(2'd3);
        #2 chk("irq_clr", 32'(bus.irq), 32'd0);

        // Write coinciding with ack of the pending word
        wr_reg(2'd0, 32'h1, 1'b0);
        wr_reg(2'd0, 32'h2, 1'b1);
        idle(2'd3);
        #2 chk("same_cycle_valid", 32'(bus.out_valid), 32'd1);
        chk("same_cycle_port", 32'(bus.out_port), 32'h2);
        rd_reg(2'd1, "same_cycle_status", 32'h9);
        rd_reg(2'd2, "same_cycle_count", 32'd2);

        // 256 back-to-back write/ack pairs wrap the counter
        wr_reg(2'd2, 32'd0, 1'b0);
        for (int i = 0; i < 256; i++) wr_reg(2'd0, 32'(i), 1'b1);
        rd_reg(2'd2, "count_wrap", 32'd0);

        // Random traffic; the compare process does the checking
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic        cs, wn, ack;
            a   = 2'($urandom_range(0, 3));
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 2) == 0);
            cyc(a, cs, wn, $urandom, ack);
        end

        // Asynchronous reset while a command is pending
        wr_reg(2'd0, 32'h2, 1'b0);
        idle(2'd3);
        #2 chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_port",  32'(bus.out_port), 32'(RSTV[DW-1:0]));
        chk("async_rst_irq",   32'(bus.irq), 32'd0);
        idle(2'd3);
        reset_n = 1'b1;
        repeat (3) idle(2'd3);
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
